// File: rtl/mem_seq.sv
// mem_seq: two-requester access sequencer for the HRM memory block.
// Accepts direct or indirect loads and stores from port 0 (CPU control) and
// port 1 (debug/loader), picks between them round-robin, and steps the memory
// strobes (ADDR, srcA, wAR, wM, R) through the required cycle order. Each
// transaction ends with a single-cycle resp_valid pulse to its owner.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/ready[1:0]  per-port request handshake (ready is combinational)
//   req_write/indirect    per-port request kind
//   req_addr/req_data     per-port address / store data, port i in [8i+7:8i]
//   resp_valid[1:0]       one-cycle completion pulse for the owning port
//   resp_data[7:0]        load result, or the written data on a store
//   busy                  high whenever a transaction is in flight
//   mem_addr/srcA/wAR/wM/R  strobes to the memory wrapper; mem_M read data
module mem_seq #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_write,
  input  logic [1:0]  req_indirect,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_data,
  output logic [1:0]  resp_valid,
  output logic [7:0]  resp_data,
  output logic        busy,
  output logic [7:0]  mem_addr,
  output logic        mem_srcA,
  output logic        mem_wAR,
  output logic        mem_wM,
  output logic [7:0]  mem_R,
  input  logic [7:0]  mem_M
);

  if (RD_LAT < 1 || RD_LAT > 7) begin : g_rd_lat_check
    $error("mem_seq: RD_LAT must be within 1..7");
  end

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_AR1   = 3'd1;
  localparam logic [2:0] ST_WAIT1 = 3'd2;
  localparam logic [2:0] ST_AR2   = 3'd3;
  localparam logic [2:0] ST_WAIT2 = 3'd4;
  localparam logic [2:0] ST_WR    = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

  logic [2:0] state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       port_q, port_d;
  logic       write_q, write_d;
  logic       ind_q, ind_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] resp_data_q, resp_data_d;

  logic [1:0] grant;

  // Only IDLE can accept. With both ports asking, the port that did not win
  // last time goes first. Reset also masks ready so that every output reads
  // 0 while rst_n is held low.
  always_comb begin
    grant = 2'b00;
    if (rst_n && state_q == ST_IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    write_d      = write_q;
    ind_d        = ind_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    resp_data_d  = resp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          port_d       = grant[1];
          last_grant_d = grant[1];
          write_d      = req_write[grant[1]];
          ind_d        = req_indirect[grant[1]];
          addr_d       = grant[1] ? req_addr[15:8] : req_addr[7:0];
          data_d       = grant[1] ? req_data[15:8] : req_data[7:0];
          state_d      = ST_AR1;
        end
      end
      ST_AR1: begin
        // A direct store needs no read; every other kind waits for M.
        if (write_q && !ind_q) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_WAIT1;
          cnt_d   = LAT_LOAD;
        end
      end
      ST_WAIT1: begin
        // cnt_q == 1 is the last wait cycle: M is valid on this edge.
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          if (ind_q) begin
            state_d = ST_AR2;
          end else begin
            resp_data_d = mem_M;
            state_d     = ST_DONE;
          end
        end
      end
      ST_AR2: begin
        if (write_q) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_WAIT2;
          cnt_d   = LAT_LOAD;
        end
      end
      ST_WAIT2: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          resp_data_d = mem_M;
          state_d     = ST_DONE;
        end
      end
      ST_WR: begin
        resp_data_d = data_q;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      write_q      <= 1'b0;
      ind_q        <= 1'b0;
      addr_q       <= 8'h00;
      data_q       <= 8'h00;
      cnt_q        <= 3'd0;
      resp_data_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      write_q      <= write_d;
      ind_q        <= ind_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Strobes are decoded straight from the state register so that an
  // asynchronous reset drops them in the same cycle.
  assign busy       = (state_q != ST_IDLE);
  assign mem_addr   = (state_q == ST_AR1) ? addr_q : 8'h00;
  assign mem_srcA   = (state_q == ST_AR2);
  assign mem_wAR    = (state_q == ST_AR1) || (state_q == ST_AR2);
  assign mem_wM     = (state_q == ST_WR);
  assign mem_R      = (write_q && state_q != ST_IDLE && state_q != ST_DONE) ? data_q : 8'h00;
  assign resp_valid = (state_q == ST_DONE) ? (port_q ? 2'b10 : 2'b01) : 2'b00;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_mem_seq.sv
// Bench for mem_seq: two instances (RD_LAT = 1 and RD_LAT = 3), each with its
// own memory model (AR register, RAM array, read delay). Table vectors,
// hand-written reset/contention sequences and random traffic are checked
// against a transaction-level reference model.
module tb_mem_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n_all;
  logic [3:0]  req_valid_all, req_write_all, req_indirect_all;
  logic [31:0] req_addr_all, req_data_all;
  logic [3:0]  req_ready_all, resp_valid_all;
  logic [15:0] resp_data_all, mem_addr_all, mem_R_all, mem_M_all;
  logic [1:0]  busy_all, mem_srcA_all, mem_wAR_all, mem_wM_all;
  logic        tb_init;
  logic [7:0]  img [256];
  logic [7:0]  ref_mem [2][256];

  int n_cmp = 0;
  int n_bad = 0;
  int viol  = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    logic [7:0] mem [256];
    logic [7:0] ar;

    mem_seq #(.RD_LAT((gi == 0) ? 1 : 3)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n_all[gi]),
      .req_valid    (req_valid_all[2*gi +: 2]),
      .req_ready    (req_ready_all[2*gi +: 2]),
      .req_write    (req_write_all[2*gi +: 2]),
      .req_indirect (req_indirect_all[2*gi +: 2]),
      .req_addr     (req_addr_all[16*gi +: 16]),
      .req_data     (req_data_all[16*gi +: 16]),
      .resp_valid   (resp_valid_all[2*gi +: 2]),
      .resp_data    (resp_data_all[8*gi +: 8]),
      .busy         (busy_all[gi]),
      .mem_addr     (mem_addr_all[8*gi +: 8]),
      .mem_srcA     (mem_srcA_all[gi]),
      .mem_wAR      (mem_wAR_all[gi]),
      .mem_wM       (mem_wM_all[gi]),
      .mem_R        (mem_R_all[8*gi +: 8]),
      .mem_M        (mem_M_all[8*gi +: 8])
    );

    always @(posedge clk) begin
      if (tb_init) begin
        for (int a = 0; a < 256; a++) mem[a] <= img[a];
        ar <= 8'h00;
      end else begin
        if (mem_wM_all[gi]) mem[ar] <= mem_R_all[8*gi +: 8];
        if (mem_wAR_all[gi]) ar <= mem_srcA_all[gi] ? mem_M_all[8*gi +: 8] : mem_addr_all[8*gi +: 8];
      end
    end

    // M becomes valid RD_LAT edges after AR loads; before that it shows stale data.
    if (gi == 0) begin : g_comb
      assign mem_M_all[7:0] = mem[ar];
    end else begin : g_dly
      logic [7:0] hist [2];
      always @(posedge clk) begin
        hist[0] <= mem[ar];
        hist[1] <= hist[0];
      end
      assign mem_M_all[15:8] = hist[1];
    end
  end

  // Continuous safety monitor: no wAR+wM overlap, never ready on both ports.
  always @(negedge clk) begin
    int s;
    s = 0;
    for (int k = 0; k < 2; k++) begin
      if (mem_wAR_all[k] && mem_wM_all[k]) s++;
      if (req_ready_all[2*k +: 2] == 2'b11) s++;
    end
    viol <= viol + s;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: resolve the target address, apply the store
  // or fetch the load value, and derive latency from the request kind.
  function automatic void model(input int k, input bit wr, input bit ind,
                                input logic [7:0] addr, input logic [7:0] data,
                                output logic [7:0] exp_d, output int lat);
    int         l;
    logic [7:0] tgt;
    l   = (k == 0) ? 1 : 3;
    tgt = ind ? ref_mem[k][addr] : addr;
    if (wr) begin
      ref_mem[k][tgt] = data;
      exp_d = data;
    end else begin
      exp_d = ref_mem[k][tgt];
    end
    lat = (wr ? 3 : 2 + l) + (ind ? 1 + l : 0);
  endfunction

  // Issue one request and follow it to its response. Entered and left just
  // after a falling edge.
  task automatic do_txn(input int k, input int port, input bit wr, input bit ind,
                        input logic [7:0] addr, input logic [7:0] data,
                        input logic [7:0] exp_d, input int exp_lat, input string tag);
    int         idx, cyc, lat, n_war, n_wm, stray, busy_bad;
    bit         got_rdy, got;
    logic [1:0] src_seq, rv;
    logic [7:0] first_addr, r_at_wm, rdata;
    idx = 2*k + port;
    n_war = 0; n_wm = 0; stray = 0; busy_bad = 0; lat = 0;
    got_rdy = 1'b0; got = 1'b0; src_seq = 2'b00; rv = 2'b00;
    first_addr = 8'h00; r_at_wm = 8'h00; rdata = 8'h00;
    req_valid_all[idx]       = 1'b1;
    req_write_all[idx]       = wr;
    req_indirect_all[idx]    = ind;
    req_addr_all[8*idx +: 8] = addr;
    req_data_all[8*idx +: 8] = data;
    for (int w = 0; w < 20; w++) begin
      #1;
      if (req_ready_all[idx]) begin
        got_rdy = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("%s_ready", tag), 32'(got_rdy), 32'd1);
    @(negedge clk);
    #1;
    // Scramble the request lines: the block must have latched them already.
    req_valid_all[idx]       = 1'b0;
    req_write_all[idx]       = 1'($urandom);
    req_indirect_all[idx]    = 1'($urandom);
    req_addr_all[8*idx +: 8] = 8'($urandom);
    req_data_all[8*idx +: 8] = 8'($urandom);
    for (cyc = 1; cyc <= 60; cyc++) begin
      rv = resp_valid_all[2*k +: 2];
      if (mem_wAR_all[k]) begin
        n_war++;
        src_seq = {src_seq[0], mem_srcA_all[k]};
        if (n_war == 1) first_addr = mem_addr_all[8*k +: 8];
      end else if (mem_srcA_all[k]) begin
        stray++;
      end
      if (mem_wM_all[k]) begin
        n_wm++;
        r_at_wm = mem_R_all[8*k +: 8];
      end
      if (!wr && mem_R_all[8*k +: 8] != 8'h00) stray++;
      if (!busy_all[k]) busy_bad++;
      if (rv != 2'b00) begin
        got   = 1'b1;
        lat   = cyc;
        rdata = resp_data_all[8*k +: 8];
        break;
      end
      @(negedge clk);
      #1;
    end
    chk($sformatf("%s_resp_seen", tag), 32'(got), 32'd1);
    chk($sformatf("%s_latency", tag), 32'(lat), 32'(exp_lat));
    chk($sformatf("%s_resp_port", tag), 32'(rv), (port == 1) ? 32'd2 : 32'd1);
    chk($sformatf("%s_resp_data", tag), 32'(rdata), 32'(exp_d));
    chk($sformatf("%s_war_count", tag), 32'(n_war), ind ? 32'd2 : 32'd1);
    chk($sformatf("%s_srcA_seq", tag), 32'(src_seq), ind ? 32'd1 : 32'd0);
    chk($sformatf("%s_ar1_addr", tag), 32'(first_addr), 32'(addr));
    chk($sformatf("%s_wm_count", tag), 32'(n_wm), wr ? 32'd1 : 32'd0);
    if (wr) chk($sformatf("%s_mem_R", tag), 32'(r_at_wm), 32'(data));
    chk($sformatf("%s_stray_strobe", tag), 32'(stray), 32'd0);
    chk($sformatf("%s_busy_during", tag), 32'(busy_bad), 32'd0);
    $display("txn %s: inst=%0d port=%0d %s %s addr=%02h data=%02h -> resp=%02h lat=%0d",
             tag, k, port, wr ? "store" : "load", ind ? "ind" : "dir", addr, data, rdata, lat);
    @(negedge clk);
    #1;
    chk($sformatf("%s_after_done", tag), 32'({busy_all[k], resp_valid_all[2*k +: 2]}), 32'd0);
  endtask

  typedef struct {
    int         k;
    int         port;
    bit         wr;
    bit         ind;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_d;
    int         exp_lat;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [7:0] md, ed, ra, rd;
    int         ml, el, rp, ng, n_resp, both, busy_bad, cur_port;
    bit         rw, ri, in_txn;
    logic [3:0] order;
    logic [1:0] rdy, rv;

    rst_n_all = 2'b00; tb_init = 1'b0;
    req_valid_all = '0; req_write_all = '0; req_indirect_all = '0;
    req_addr_all = '0; req_data_all = '0;
    for (int a = 0; a < 256; a++) img[a] = 8'(a * 13 + 7);
    img[8'h10] = 8'h5A; img[8'h20] = 8'h30; img[8'h30] = 8'hC3; img[8'h06] = 8'h40;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 256; a++) ref_mem[k][a] = img[a];

    // k, port, wr, ind, addr, data, expected data, expected latency
    tbl[0]  = '{0, 0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h5A, 3};
    tbl[1]  = '{0, 1, 1'b0, 1'b1, 8'h20, 8'h00, 8'hC3, 5};
    tbl[2]  = '{0, 0, 1'b1, 1'b0, 8'h05, 8'h7E, 8'h7E, 3};
    tbl[3]  = '{0, 1, 1'b1, 1'b1, 8'h06, 8'h11, 8'h11, 5};
    tbl[4]  = '{0, 1, 1'b0, 1'b0, 8'h05, 8'h00, 8'h7E, 3};
    tbl[5]  = '{0, 0, 1'b0, 1'b0, 8'h40, 8'h00, 8'h11, 3};
    tbl[6]  = '{0, 0, 1'b0, 1'b1, 8'h06, 8'h00, 8'h11, 5};
    tbl[7]  = '{1, 0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h5A, 5};
    tbl[8]  = '{1, 1, 1'b0, 1'b1, 8'h20, 8'h00, 8'hC3, 9};
    tbl[9]  = '{1, 0, 1'b1, 1'b1, 8'h06, 8'h22, 8'h22, 7};
    tbl[10] = '{1, 1, 1'b0, 1'b0, 8'h40, 8'h00, 8'h22, 5};

    @(negedge clk);
    tb_init = 1'b1;
    @(negedge clk);
    tb_init = 1'b0;
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("reset_outputs_i%0d", k),
          {req_ready_all[2*k +: 2], resp_valid_all[2*k +: 2], resp_data_all[8*k +: 8],
           busy_all[k], mem_addr_all[8*k +: 8], mem_srcA_all[k], mem_wAR_all[k],
           mem_wM_all[k]}, 32'd0);
    rst_n_all = 2'b11;
    @(negedge clk);
    #1;
    chk("post_reset_idle", {busy_all, mem_R_all}, 32'd0);

    // Table vectors
    for (int t = 0; t < 11; t++) begin
      model(tbl[t].k, tbl[t].wr, tbl[t].ind, tbl[t].addr, tbl[t].data, md, ml);
      do_txn(tbl[t].k, tbl[t].port, tbl[t].wr, tbl[t].ind, tbl[t].addr, tbl[t].data,
             tbl[t].exp_d, tbl[t].exp_lat, $sformatf("tbl%0d", t));
    end

    // Reset during WAIT2 of an indirect load (instance 0, RD_LAT = 1)
    req_valid_all[1] = 1'b1; req_write_all[1] = 1'b0; req_indirect_all[1] = 1'b1;
    req_addr_all[15:8] = 8'h20;
    for (int w = 0; w < 10 && !req_ready_all[1]; w++) begin
      #1;
      if (!req_ready_all[1]) @(negedge clk);
    end
    @(negedge clk);
    #1;
    req_valid_all[1] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_wait2_busy", {busy_all[0], mem_wAR_all[0], mem_wM_all[0]}, 32'h4);
    rst_n_all[0] = 1'b0;
    #1;
    chk("rst_strobes_drop",
        {mem_wAR_all[0], mem_wM_all[0], mem_srcA_all[0], busy_all[0],
         resp_valid_all[1:0], mem_addr_all[7:0], mem_R_all[7:0]}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst_no_resp_c%0d", c), {busy_all[0], resp_valid_all[1:0]}, 32'd0);
    end
    rst_n_all[0] = 1'b1;
    do_txn(0, 0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h5A, 3, "after_rst");

    // Contention from reset: both ports valid throughout
    rst_n_all[0] = 1'b0;
    req_valid_all[1:0] = 2'b11; req_write_all[1:0] = 2'b00; req_indirect_all[1:0] = 2'b00;
    req_addr_all[15:0] = {8'h30, 8'h10};
    #1;
    chk("cont_ready_in_reset", 32'(req_ready_all[1:0]), 32'd0);
    @(negedge clk);
    #1;
    rst_n_all[0] = 1'b1;
    ng = 0; n_resp = 0; both = 0; busy_bad = 0; in_txn = 1'b0; order = 4'b0000; cur_port = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      rdy = req_ready_all[1:0];
      rv  = resp_valid_all[1:0];
      if (rdy == 2'b11) both++;
      if (in_txn != busy_all[0]) busy_bad++;
      if (rv != 2'b00) begin
        n_resp++;
        chk($sformatf("cont_resp_port%0d", n_resp), 32'(rv), (cur_port == 1) ? 32'd2 : 32'd1);
        chk($sformatf("cont_resp_data%0d", n_resp), 32'(resp_data_all[7:0]),
            (cur_port == 1) ? 32'hC3 : 32'h5A);
        in_txn = 1'b0;
      end
      if (rdy != 2'b00 && ng < 4) begin
        order[ng] = rdy[1];
        cur_port  = int'(rdy[1]);
        ng++;
        in_txn = 1'b1;
      end
      if (ng == 4 && !in_txn) break;
      @(negedge clk);
    end
    req_valid_all[1:0] = 2'b00;
    chk("cont_grants", 32'(ng), 32'd4);
    chk("cont_order", 32'(order), 32'b1010);
    chk("cont_resps", 32'(n_resp), 32'd4);
    chk("cont_both_ready", 32'(both), 32'd0);
    chk("cont_busy", 32'(busy_bad), 32'd0);
    @(negedge clk);
    #1;

    // Random traffic against the reference model
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 25; n++) begin
        rp = int'($urandom_range(0, 1));
        rw = 1'($urandom);
        ri = 1'($urandom);
        ra = 8'($urandom);
        rd = 8'($urandom);
        model(k, rw, ri, ra, rd, ed, el);
        do_txn(k, rp, rw, ri, ra, rd, ed, el, $sformatf("rnd%0d_%0d", k, n));
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          #1;
        end
      end
    end

    chk("strobe_and_ready_monitor", 32'(viol), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_seq.md
Name: mem_seq

Overview:
- Two-requester access sequencer and arbiter for the HRM memory block: the AR address register, the srcA mux, and the synchronous RAM/MMIO wrapper.
- Takes load/store requests, direct or indirect, from the CPU control unit (port 0) and the debug/loader interface (port 1).
- Arbitrates round-robin between the two ports.
- Drives the memory control strobes (ADDR, srcA, wAR, wM, R) in the required cycle order and returns a one-cycle response.

Parameters:
- RD_LAT, 1, cycles from the AR-load edge until M is valid. Legal values 1..7; 0 is illegal and must be rejected by an elaboration-time check.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  bit i: port i has a request pending
- req_ready  out  2  bit i: port i request accepted this cycle
- req_write  in  2  bit i: 1 = store, 0 = load
- req_indirect  in  2  bit i: 1 = address is taken from mem[req_addr]
- req_addr  in  16  port i address in bits [8i+7:8i]
- req_data  in  16  port i store data in bits [8i+7:8i]
- resp_valid  out  2  bit i: one-cycle completion pulse for port i
- resp_data  out  8  load result, or the written data on a store
- busy  out  1  high in every state except IDLE
- mem_addr  out  8  to memory ADDR
- mem_srcA  out  1  to memory srcA (0 = ADDR, 1 = M)
- mem_wAR  out  1  to memory wAR
- mem_wM  out  1  to memory wM
- mem_R  out  8  to memory R (store data)
- mem_M  in  8  from memory M

Behaviour:
- Reset (async, immediate):
  - State = IDLE; all outputs 0; last_grant = 1, so port 0 wins the first contention.
  - A reset mid-operation drops all strobes at once, issues no resp_valid and loses the request.
  - AR contents are not touched by this block.
- IDLE:
  - req_ready is combinational: only the granted port sees it high.
  - One port valid: grant it. Both valid: grant the port opposite last_grant.
  - On the accept edge: latch write, indirect, addr, data and the port id; set last_grant; go to AR1.
- AR1: mem_addr = addr_q, mem_srcA = 0, mem_wAR = 1 for exactly one cycle.
  - Direct store: go to WR.
  - Any other case: go to WAIT1 with the counter loaded to RD_LAT.
- WAIT1: no strobes. Decrement the counter; when it reaches 0, branch:
  - Indirect request: go to AR2.
  - Direct load: capture mem_M into resp_data and go to DONE.
- AR2: mem_srcA = 1, mem_wAR = 1 for one cycle, loading AR from M.
  - Store: go to WR.
  - Load: go to WAIT2 with the counter loaded to RD_LAT.
- WAIT2: as WAIT1. At 0, capture mem_M and go to DONE.
- WR: mem_wM = 1 and mem_R = data_q for exactly one cycle. resp_data <= data_q. Go to DONE.
- DONE: resp_valid[port_q] = 1 for one cycle, then go to IDLE. No request is accepted in DONE.
- Strobe rules:
  - Outside the owning states, mem_wAR, mem_wM and mem_srcA are 0.
  - mem_R holds data_q while a store is active, otherwise 0.
  - mem_wAR and mem_wM are never high in the same cycle.
- Latency, counted from accept edge to the resp_valid cycle; I = 1 + RD_LAT:
  - Direct load: 2 + RD_LAT.
  - Indirect load: 2 + RD_LAT + I.
  - Direct store: 3.
  - Indirect store: 3 + I.
- Throughput: a new accept is possible one cycle after DONE, from IDLE.
- Request inputs are sampled only on the accept edge. Later changes on any port are ignored.
- resp_data holds its value until the next capture.

Test Plan:
- Direct load, RD_LAT = 1: mem[0x10] = 0x5A; port 0 loads 0x10.
  -> mem_wAR pulses once with srcA = 0 and ADDR = 0x10.
  -> resp_valid[0] three cycles after accept, resp_data = 0x5A.
- Indirect load: mem[0x20] = 0x30, mem[0x30] = 0xC3; port 1 indirect load 0x20.
  -> two wAR pulses, the second with srcA = 1.
  -> resp_valid[1] at cycle 5, resp_data = 0xC3; resp_valid[0] stays 0.
- Direct store 0x7E to 0x05, then indirect store 0x11 via mem[0x06] = 0x40.
  -> exactly one wM cycle each, with mem_R = 0x7E and 0x11.
  -> acks at cycles 3 and 5; readbacks return mem[0x05] = 0x7E and mem[0x40] = 0x11.
- Contention: both ports valid continuously from reset.
  -> grant order 0, 1, 0, 1.
  -> req_ready is never high on both ports at once; busy is high between each accept and its DONE.
- Async reset during WAIT2 of an indirect load.
  -> strobes go to 0 within the same cycle and no resp_valid is issued.
  -> after release, a direct load of 0x10 returns 0x5A with normal latency.
- RD_LAT = 3 build.
  -> direct load responds at cycle 5; indirect load responds at cycle 9.
